// File: rtl/sram_controller_pwr_fsm.sv
// ---------------------------------------------------------------------------
// sram_controller_pwr_fsm
//
// Power-mode sequencer for the SRAM controller, running in the controller
// clock domain. A save request drains outstanding traffic, then walks the
// SRAM through isolation, retention and periphery power-off. A restore
// request runs the reverse sequence. Completion and drain timeouts are
// reported back to the PMU handshake logic as one-cycle pulses.
//
// Optional build macro: SRAM_PWR_FSM_STATS_EN adds the ret_entry_cnt output,
// a saturating count of retention entries.
//
// Ports:
//   clk_ctrl              in   controller clock
//   reset                 in   asynchronous reset, active-high
//   pwr_save_req_sync     in   synchronized save request (level)
//   pwr_restore_req_sync  in   synchronized restore request (level)
//   ctrl_idle             in   controller has no outstanding transactions
//   req_block             out  stall new host requests
//   sram_iso_en           out  SRAM output isolation enable
//   sram_ret_en           out  SRAM array retention enable
//   sram_pwr_on           out  SRAM periphery power enable
//   pwr_save_ack          out  pulse: retention entered
//   pwr_restore_ack       out  pulse: back in ACTIVE after restore
//   pwr_save_abort        out  pulse: drain timed out
//   pwr_state             out  current state encoding
//   ret_entry_cnt[15:0]   out  retention entry count (SRAM_PWR_FSM_STATS_EN)
// ---------------------------------------------------------------------------
module sram_controller_pwr_fsm #(
    parameter int DRAIN_TIMEOUT    = 64,
    parameter int ISO_SETUP_CYCLES = 4,
    parameter int WAKE_CYCLES      = 16,
    parameter int CNT_W            = 8
) (
    input  logic        clk_ctrl,
    input  logic        reset,
    input  logic        pwr_save_req_sync,
    input  logic        pwr_restore_req_sync,
    input  logic        ctrl_idle,
    output logic        req_block,
    output logic        sram_iso_en,
    output logic        sram_ret_en,
    output logic        sram_pwr_on,
    output logic        pwr_save_ack,
    output logic        pwr_restore_ack,
    output logic        pwr_save_abort,
`ifdef SRAM_PWR_FSM_STATS_EN
    output logic [15:0] ret_entry_cnt,
`endif
    output logic [2:0]  pwr_state
);

    typedef enum logic [2:0] {
        ST_ACTIVE      = 3'd0,
        ST_DRAIN       = 3'd1,
        ST_ISO_SETUP   = 3'd2,
        ST_RETENTION   = 3'd3,
        ST_WAKE        = 3'd4,
        ST_ISO_RELEASE = 3'd5
    } pwr_state_t;

    // Terminal counter values: a phase of N cycles ends when the counter,
    // which starts at 0 on phase entry, reaches N-1.
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ISO_LAST   = CNT_W'(ISO_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);

    pwr_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             save_armed_q, save_armed_d;
    logic             armed_clear;
    logic             req_block_d, iso_d, ret_d, pwr_on_d;
    logic             save_ack_d, restore_ack_d, abort_d;

    // State, counter and all outputs are registered; the combinational block
    // below precomputes their next values so outputs always match pwr_state.
    always_ff @(posedge clk_ctrl or posedge reset) begin
        if (reset) begin
            state_q         <= ST_ACTIVE;
            cnt_q           <= '0;
            save_armed_q    <= 1'b0;
            req_block       <= 1'b0;
            sram_iso_en     <= 1'b0;
            sram_ret_en     <= 1'b0;
            sram_pwr_on     <= 1'b1;
            pwr_save_ack    <= 1'b0;
            pwr_restore_ack <= 1'b0;
            pwr_save_abort  <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            save_armed_q    <= save_armed_d;
            req_block       <= req_block_d;
            sram_iso_en     <= iso_d;
            sram_ret_en     <= ret_d;
            sram_pwr_on     <= pwr_on_d;
            pwr_save_ack    <= save_ack_d;
            pwr_restore_ack <= restore_ack_d;
            pwr_save_abort  <= abort_d;
        end
    end

    // Next-state logic. The counter is shared by every timed phase and is
    // cleared on each transition so the next phase starts counting from 0.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        armed_clear   = 1'b0;
        save_ack_d    = 1'b0;
        restore_ack_d = 1'b0;
        abort_d       = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (pwr_save_req_sync && !pwr_restore_req_sync && save_armed_q) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (!pwr_save_req_sync || pwr_restore_req_sync) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else if (ctrl_idle) begin
                    state_d = ST_ISO_SETUP;
                    cnt_d   = '0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d     = ST_ACTIVE;
                    cnt_d       = '0;
                    abort_d     = 1'b1;
                    armed_clear = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ISO_SETUP: begin
                if (cnt_q == ISO_LAST) begin
                    state_d     = ST_RETENTION;
                    cnt_d       = '0;
                    save_ack_d  = 1'b1;
                    armed_clear = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RETENTION: begin
                if (pwr_restore_req_sync) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                end
            end
            ST_WAKE: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d = ST_ISO_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ISO_RELEASE: begin
                if (cnt_q == ISO_LAST) begin
                    state_d       = ST_ACTIVE;
                    cnt_d         = '0;
                    restore_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
                cnt_d   = '0;
            end
        endcase

        // A low request re-arms; that observation wins over a same-cycle
        // clear because the request really was released.
        if (!pwr_save_req_sync) begin
            save_armed_d = 1'b1;
        end else if (armed_clear) begin
            save_armed_d = 1'b0;
        end else begin
            save_armed_d = save_armed_q;
        end
    end

    // Output levels are a pure function of the next state, so they land in
    // their registers together with the state itself.
    always_comb begin
        req_block_d = 1'b0;
        iso_d       = 1'b0;
        ret_d       = 1'b0;
        pwr_on_d    = 1'b1;
        case (state_d)
            ST_DRAIN: begin
                req_block_d = 1'b1;
            end
            ST_ISO_SETUP, ST_ISO_RELEASE: begin
                req_block_d = 1'b1;
                iso_d       = 1'b1;
            end
            ST_RETENTION: begin
                req_block_d = 1'b1;
                iso_d       = 1'b1;
                ret_d       = 1'b1;
                pwr_on_d    = 1'b0;
            end
            ST_WAKE: begin
                req_block_d = 1'b1;
                iso_d       = 1'b1;
                ret_d       = 1'b1;
            end
            default: begin
                req_block_d = 1'b0;
            end
        endcase
    end

    assign pwr_state = state_q;

`ifdef SRAM_PWR_FSM_STATS_EN
    // Saturating retention-entry counter, stepping on the same edge that
    // raises pwr_save_ack.
    logic [15:0] ret_cnt_q;

    always_ff @(posedge clk_ctrl or posedge reset) begin
        if (reset) begin
            ret_cnt_q <= '0;
        end else if (save_ack_d && (ret_cnt_q != 16'hFFFF)) begin
            ret_cnt_q <= ret_cnt_q + 16'd1;
        end
    end

    assign ret_entry_cnt = ret_cnt_q;
`endif

endmodule
